// File: rtl/vga_sprite_controller.sv
// VGA timing generator with up to N_SPRITES solid rectangles composited over a background colour.
// Define VGA_FRAME_LATCH_EN to double-buffer the register set and commit it at the start of vertical blank.

module vga_sprite_regs #(
    parameter int N_SPRITES = 8,
    parameter int COORD_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [7:0]           wr_addr,
    input  logic [31:0]          wr_data,
`ifdef VGA_FRAME_LATCH_EN
    input  logic                 commit,
`endif
    output logic [N_SPRITES-1:0] mask,
    output logic [23:0]          bg,
    output logic [COORD_W-1:0]   x0  [N_SPRITES],
    output logic [COORD_W-1:0]   y0  [N_SPRITES],
    output logic [COORD_W-1:0]   w   [N_SPRITES],
    output logic [COORD_W-1:0]   h   [N_SPRITES],
    output logic [23:0]          col [N_SPRITES]
);
    localparam logic [23:0] BG_RST = 24'h150088;

    // *_s is the set that writes modify; *_n is that set with this cycle's write applied
    logic [N_SPRITES-1:0] mask_s, mask_n;
    logic [23:0]          bg_s, bg_n;
    logic [COORD_W-1:0]   x0_s [N_SPRITES], x0_n [N_SPRITES];
    logic [COORD_W-1:0]   y0_s [N_SPRITES], y0_n [N_SPRITES];
    logic [COORD_W-1:0]   w_s  [N_SPRITES], w_n  [N_SPRITES];
    logic [COORD_W-1:0]   h_s  [N_SPRITES], h_n  [N_SPRITES];
    logic [23:0]          col_s [N_SPRITES], col_n [N_SPRITES];

    logic unused_data_hi;
    assign unused_data_hi = ^wr_data[31:24];

    always_comb begin
        mask_n = mask_s;
        bg_n   = bg_s;
        for (int i = 0; i < N_SPRITES; i++) begin
            x0_n[i]  = x0_s[i];
            y0_n[i]  = y0_s[i];
            w_n[i]   = w_s[i];
            h_n[i]   = h_s[i];
            col_n[i] = col_s[i];
        end
        if (wr_en) begin
            if (wr_addr == 8'h00) mask_n = wr_data[N_SPRITES-1:0];
            if (wr_addr == 8'h01) bg_n = wr_data[23:0];
            for (int i = 0; i < N_SPRITES; i++) begin
                if (wr_addr[7:3] == 5'(i + 1)) begin
                    case (wr_addr[2:0])
                        3'd0:    x0_n[i]  = wr_data[COORD_W-1:0];
                        3'd1:    y0_n[i]  = wr_data[COORD_W-1:0];
                        3'd2:    w_n[i]   = wr_data[COORD_W-1:0];
                        3'd3:    h_n[i]   = wr_data[COORD_W-1:0];
                        3'd4:    col_n[i] = wr_data[23:0];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef VGA_FRAME_LATCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_s <= '0;
            bg_s   <= BG_RST;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0_s[i]  <= '0;
                y0_s[i]  <= '0;
                w_s[i]   <= '0;
                h_s[i]   <= '0;
                col_s[i] <= '0;
            end
        end else begin
            mask_s <= mask_n;
            bg_s   <= bg_n;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0_s[i]  <= x0_n[i];
                y0_s[i]  <= y0_n[i];
                w_s[i]   <= w_n[i];
                h_s[i]   <= h_n[i];
                col_s[i] <= col_n[i];
            end
        end
    end

    // Committing *_n lets a write coinciding with the boundary land in this frame
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            bg   <= BG_RST;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0[i]  <= '0;
                y0[i]  <= '0;
                w[i]   <= '0;
                h[i]   <= '0;
                col[i] <= '0;
            end
        end else if (commit) begin
            mask <= mask_n;
            bg   <= bg_n;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0[i]  <= x0_n[i];
                y0[i]  <= y0_n[i];
                w[i]   <= w_n[i];
                h[i]   <= h_n[i];
                col[i] <= col_n[i];
            end
        end
    end
`else
    always_comb begin
        mask_s = mask;
        bg_s   = bg;
        for (int i = 0; i < N_SPRITES; i++) begin
            x0_s[i]  = x0[i];
            y0_s[i]  = y0[i];
            w_s[i]   = w[i];
            h_s[i]   = h[i];
            col_s[i] = col[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            bg   <= BG_RST;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0[i]  <= '0;
                y0[i]  <= '0;
                w[i]   <= '0;
                h[i]   <= '0;
                col[i] <= '0;
            end
        end else begin
            mask <= mask_n;
            bg   <= bg_n;
            for (int i = 0; i < N_SPRITES; i++) begin
                x0[i]  <= x0_n[i];
                y0[i]  <= y0_n[i];
                w[i]   <= w_n[i];
                h[i]   <= h_n[i];
                col[i] <= col_n[i];
            end
        end
    end
`endif

endmodule

module vga_sprite_controller #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int N_SPRITES = 8,
    parameter int COORD_W   = 11
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    input  logic        iWR_EN,
    input  logic [7:0]  iWR_ADDR,
    input  logic [31:0] iWR_DATA,
    output logic        oBLANK_n,
    output logic        oHS,
    output logic        oVS,
    output logic [7:0]  b_data,
    output logic [7:0]  g_data,
    output logic [7:0]  r_data,
    output logic        oFRAME
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [N_SPRITES-1:0] mask;
    logic [23:0]          bg;
    logic [COORD_W-1:0]   x0  [N_SPRITES];
    logic [COORD_W-1:0]   y0  [N_SPRITES];
    logic [COORD_W-1:0]   w   [N_SPRITES];
    logic [COORD_W-1:0]   h   [N_SPRITES];
    logic [23:0]          col [N_SPRITES];

    logic [COORD_W-1:0]   h_cnt, v_cnt;
    logic                 at_frame, act_c, hs_c, vs_c;
    logic [N_SPRITES-1:0] hit_c;
    logic                 act_q, hs_q, vs_q, frm_q;
    logic [N_SPRITES-1:0] hit_q;
    logic [23:0]          pix_c;

    vga_sprite_regs #(
        .N_SPRITES (N_SPRITES),
        .COORD_W   (COORD_W)
    ) u_regs (
        .clk     (iVGA_CLK),
        .rst     (iRST),
        .wr_en   (iWR_EN),
        .wr_addr (iWR_ADDR),
        .wr_data (iWR_DATA),
`ifdef VGA_FRAME_LATCH_EN
        .commit  (at_frame),
`endif
        .mask    (mask),
        .bg      (bg),
        .x0      (x0),
        .y0      (y0),
        .w       (w),
        .h       (h),
        .col     (col)
    );

    // S0: raster position
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
        end else begin
            h_cnt <= h_cnt + COORD_W'(1);
        end
    end

    // Bounds are widened by one bit so rectangles running off the edge clip instead of wrapping
    always_comb begin
        at_frame = (h_cnt == '0) && (v_cnt == V_ACT);
        act_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c     = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_c     = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
        hit_c    = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            hit_c[i] = mask[i]
                && ({1'b0, h_cnt} >= {1'b0, x0[i]})
                && ({1'b0, h_cnt} <  ({1'b0, x0[i]} + {1'b0, w[i]}))
                && ({1'b0, v_cnt} >= {1'b0, y0[i]})
                && ({1'b0, v_cnt} <  ({1'b0, y0[i]} + {1'b0, h[i]}));
        end
    end

    // S1: hit vector and timing flags
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hit_q <= '0;
            act_q <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            frm_q <= 1'b0;
        end else begin
            hit_q <= hit_c;
            act_q <= act_c;
            hs_q  <= hs_c;
            vs_q  <= vs_c;
            frm_q <= at_frame;
        end
    end

    always_comb begin
        pix_c = bg;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) pix_c = col[i];
        end
        if (!act_q) pix_c = '0;
    end

    // S2: output register
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            {b_data, g_data, r_data} <= '0;
            oBLANK_n <= 1'b0;
            oHS      <= ~SYNC_POL;
            oVS      <= ~SYNC_POL;
            oFRAME   <= 1'b0;
        end else begin
            {b_data, g_data, r_data} <= pix_c;
            oBLANK_n <= act_q;
            oHS      <= hs_q;
            oVS      <= vs_q;
            oFRAME   <= frm_q;
        end
    end

endmodule

// File: tb/tb_vga_sprite_controller.sv
// Bench for vga_sprite_controller on a reduced 80x55 raster: per-cycle model comparison plus
// hand-computed probes. Follows VGA_FRAME_LATCH_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_vga_sprite_controller;
    localparam int HA  = 64;
    localparam int HF  = 4;
    localparam int HSW = 8;
    localparam int HB  = 4;
    localparam int VA  = 48;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int NS  = 8;
    localparam logic [23:0] BG_RST = 24'h150088;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        blank_n, hs, vs, frame;
    logic [7:0]  b_data, g_data, r_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_sprite_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .SYNC_POL (1'b0), .N_SPRITES (NS), .COORD_W (11)
    ) dut (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .iWR_EN   (wr_en),
        .iWR_ADDR (wr_addr),
        .iWR_DATA (wr_data),
        .oBLANK_n (blank_n),
        .oHS      (hs),
        .oVS      (vs),
        .b_data   (b_data),
        .g_data   (g_data),
        .r_data   (r_data),
        .oFRAME   (frame)
    );

    typedef struct {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic        frame;
        logic [23:0] rgb;
        int          h;
        int          v;
    } exp_t;

    // p_* receives writes, l_* is what the picture is drawn from
    logic [NS-1:0] p_mask, l_mask;
    logic [23:0]   p_bg, l_bg;
    int            p_x[NS], p_y[NS], p_w[NS], p_h[NS];
    int            l_x[NS], l_y[NS], l_w[NS], l_h[NS];
    logic [23:0]   p_c[NS], l_c[NS];
    int            m_h = 0, m_v = 0;
    exp_t          d1, d2;
    bit            chk_en = 1'b0;

    function automatic exp_t idle_out();
        exp_t e;
        e.blank_n = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.frame = 1'b0;
        e.rgb = '0; e.h = -1; e.v = -1;
        return e;
    endfunction

    function automatic exp_t expect_px(int h, int v);
        exp_t e;
        bit   found;
        e.h = h; e.v = v;
        e.blank_n = (h < HA) && (v < VA);
        e.hs      = !(h >= HA + HF && h < HA + HF + HSW);
        e.vs      = !(v >= VA + VF && v < VA + VF + VSW);
        e.frame   = (h == 0) && (v == VA);
        e.rgb     = '0;
        if (e.blank_n) begin
            e.rgb = l_bg;
            found = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (!found && l_mask[i] && h >= l_x[i] && h < l_x[i] + l_w[i]
                    && v >= l_y[i] && v < l_y[i] + l_h[i]) begin
                    e.rgb = l_c[i];
                    found = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic void commit_regs();
        l_mask = p_mask; l_bg = p_bg;
        l_x = p_x; l_y = p_y; l_w = p_w; l_h = p_h; l_c = p_c;
    endfunction

    function automatic void clear_regs();
        p_mask = '0; p_bg = BG_RST;
        for (int i = 0; i < NS; i++) begin
            p_x[i] = 0; p_y[i] = 0; p_w[i] = 0; p_h[i] = 0; p_c[i] = '0;
        end
        commit_regs();
    endfunction

    function automatic void apply_write(logic [7:0] a, logic [31:0] d);
        int slot, f;
        slot = int'(a) / 8;
        f    = int'(a) % 8;
        if (a == 8'h00) p_mask = d[NS-1:0];
        else if (a == 8'h01) p_bg = d[23:0];
        else if (slot >= 1 && slot <= NS) begin
            case (f)
                0: p_x[slot-1] = int'(d[10:0]);
                1: p_y[slot-1] = int'(d[10:0]);
                2: p_w[slot-1] = int'(d[10:0]);
                3: p_h[slot-1] = int'(d[10:0]);
                4: p_c[slot-1] = d[23:0];
                default: ;
            endcase
        end
    endfunction

    // Model: d1/d2 hold what the outputs must show one and two cycles after the raster position
    always @(posedge clk) begin
        if (rst) begin
            m_h = 0; m_v = 0;
            d1 = idle_out(); d2 = idle_out();
            clear_regs();
        end else begin
            d2 = d1;
            d1 = expect_px(m_h, m_v);
            if (wr_en) apply_write(wr_addr, wr_data);
`ifdef VGA_FRAME_LATCH_EN
            if (m_h == 0 && m_v == VA) commit_regs();
`else
            commit_regs();
`endif
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [27:0] act, exp;
        if (chk_en) begin
            act = {blank_n, hs, vs, frame, b_data, g_data, r_data};
            exp = {d2.blank_n, d2.hs, d2.vs, d2.frame, d2.rgb};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL pixel h=%0d v=%0d: got blank/hs/vs/frame/bgr=%h, expected %h",
                         d2.h, d2.v, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_out(input int h, input int v);
        int n = 0;
        while (!(d2.h == h && d2.v == v)) begin
            if (n == 3 * HT * VT) begin timed_out("wait_out"); return; end
            @(negedge clk); n++;
        end
    endtask

    task automatic wait_cnt(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v)) begin
            if (n == 3 * HT * VT) begin timed_out("wait_cnt"); return; end
            @(negedge clk); n++;
        end
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [23:0] rgb);
        wait_out(h, v);
        check(name, {8'h00, b_data, g_data, r_data}, {8'h00, rgb});
    endtask

    // Writes are placed in horizontal blanking so they never land next to a visible pixel
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        while (!(m_h >= HA + 2 && m_h <= HT - 3) && n < 4 * HT) begin
            @(negedge clk); n++;
        end
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic settle();
        wait_cnt(1, VA);
        wait_cnt(0, 0);
    endtask

    initial begin
        int hs_cyc, hs_pul, vs_cyc, vs_pul, blk, frm, nonbg, k;
        logic prev_hs, prev_vs;
        hs_cyc = 0; hs_pul = 0; vs_cyc = 0; vs_pul = 0; blk = 0; frm = 0; nonbg = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_blank_n", {31'b0, blank_n}, 0);
        check("rst_hs", {31'b0, hs}, 1);
        check("rst_vs", {31'b0, vs}, 1);
        check("rst_frame", {31'b0, frame}, 0);
        check("rst_rgb", {8'h00, b_data, g_data, r_data}, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // One whole frame of default output
        wait_out(0, 0);
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 0; i < HT * VT; i++) begin
            if (!hs) hs_cyc++;
            if (!hs && prev_hs) hs_pul++;
            if (!vs) vs_cyc++;
            if (!vs && prev_vs) vs_pul++;
            if (blank_n) blk++;
            if (frame) frm++;
            if (blank_n && {b_data, g_data, r_data} != BG_RST) nonbg++;
            prev_hs = hs; prev_vs = vs;
            @(negedge clk);
        end
        check("hs_cycles", hs_cyc, 440);
        check("hs_pulses", hs_pul, 55);
        check("vs_cycles", vs_cyc, 160);
        check("vs_pulses", vs_pul, 1);
        check("active_cycles", blk, 3072);
        check("frame_pulses", frm, 1);
        check("non_bg_pixels", nonbg, 0);

        // Single sprite, edges of the rectangle
        wr(8'h08, 10); wr(8'h09, 5); wr(8'h0A, 20); wr(8'h0B, 10);
        wr(8'h0C, 32'h0000FF); wr(8'h00, 1);
        settle();
        probe("s0_tl", 10, 5, 24'h0000FF);
        probe("s0_tr", 29, 5, 24'h0000FF);
        probe("s0_right_out", 30, 5, BG_RST);
        probe("s0_left_out", 9, 14, BG_RST);
        probe("s0_br", 29, 14, 24'h0000FF);
        probe("s0_below", 10, 15, BG_RST);

        // Overlap priority, then drop sprite 0 from the mask
        wr(8'h10, 20); wr(8'h11, 8); wr(8'h12, 20); wr(8'h13, 10);
        wr(8'h14, 32'h00FF00); wr(8'h00, 3);
        settle();
        probe("ovl_s0_wins", 25, 10, 24'h0000FF);
        probe("s1_only", 35, 10, 24'h00FF00);
        probe("s1_below_s0", 25, 16, 24'h00FF00);
        wr(8'h00, 2);
        settle();
        probe("s0_masked", 15, 10, BG_RST);
        probe("ovl_s1_shows", 25, 10, 24'h00FF00);

        // Right-edge clipping, coordinate-sum overflow, zero width, unmapped writes
        wr(8'h18, 60); wr(8'h19, 20); wr(8'h1A, 50); wr(8'h1B, 4); wr(8'h1C, 32'hFF0000);
        wr(8'h20, 2040); wr(8'h21, 0); wr(8'h22, 20); wr(8'h23, 48); wr(8'h24, 32'h123456);
        wr(8'h28, 0); wr(8'h29, 0); wr(8'h2A, 0); wr(8'h2B, 48); wr(8'h2C, 32'h654321);
        wr(8'h01, 32'h332211);
        wr(8'h58, 5); wr(8'h1D, 0); wr(8'h02, 0);
        wr(8'h00, 32'h1C);
        settle();
        probe("zero_w", 0, 20, 24'h332211);
        probe("no_sum_wrap", 5, 20, 24'h332211);
        probe("s2_left_out", 59, 20, 24'h332211);
        probe("s2_left", 60, 20, 24'hFF0000);
        probe("s2_last_col", 63, 20, 24'hFF0000);
        probe("s2_no_wrap", 0, 21, 24'h332211);
        probe("s3_no_wrap", 11, 30, 24'h332211);
        probe("bg_written", 50, 40, 24'h332211);

        // Colour write in the middle of a frame
        wr(8'h0B, 30); wr(8'h00, 1);
        settle();
        probe("mid_before", 15, 10, 24'h0000FF);
        wait_cnt(HA + 4, 19);
        wr(8'h0C, 32'h00AA00);
`ifdef VGA_FRAME_LATCH_EN
        probe("mid_after", 15, 25, 24'h0000FF);
`else
        probe("mid_after", 15, 25, 24'h00AA00);
`endif
        probe("next_frame", 15, 10, 24'h00AA00);

        // One-cycle reset in the middle of the frame
        wait_cnt(10, 30);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_blank_n", {31'b0, blank_n}, 0);
        check("midrst_hs", {31'b0, hs}, 1);
        check("midrst_vs", {31'b0, vs}, 1);
        check("midrst_frame", {31'b0, frame}, 0);
        check("midrst_rgb", {8'h00, b_data, g_data, r_data}, 0);
        rst = 1'b0;
        k = 0;
        while (vs !== 1'b0 && k < 6000) begin
            @(negedge clk); k++;
        end
        check("vs_after_reset", k, 4002);
        probe("post_rst_bg", 10, 10, BG_RST);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sprite_controller.md
# vga_sprite_controller

Parametrised VGA timing and pixel-composition engine for the display path. Generates HS/VS/BLANK from configurable timing parameters, tracks pixel column/row with counters (no divide), and composites up to N_SPRITES processor-programmable solid rectangles over a background colour. Sits between the processor register bus (sprite/toggle writes) and the DAC pins, the successor to the fixed 640x480 controller.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP, 16; H_SYNC, 96; H_BP, 48 (pixel clocks)
- V_ACTIVE, 480, visible lines; V_FP, 10; V_SYNC, 2; V_BP, 33 (lines)
- SYNC_POL, 0, active level of oHS/oVS
- N_SPRITES, 8, rectangles supported, 1..15
- COORD_W, 11, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iWR_EN  in  1  register write strobe, one write per cycle
- iWR_ADDR  in  8  register address
- iWR_DATA  in  32  write data
- oBLANK_n  out  1  high during active video
- oHS, oVS  out  1 each  sync, polarity SYNC_POL
- b_data, g_data, r_data  out  8 each  pixel colour
- oFRAME  out  1  one-cycle pulse at first cycle of vertical front porch

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params); wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0. Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. HS active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS likewise on v_cnt.
- Register map (writes to unmapped addresses ignored, no read-back): 0x00 enable mask [N_SPRITES-1:0]; 0x01 background colour [23:0]; sprite i at 0x08*(i+1)+f: f=0 x0, 1 y0, 2 w, 3 h (each COORD_W bits, low bits of data), 4 colour [23:0].
- Colour word is {b,g,r}: b=[23:16], g=[15:8], r=[7:0].
- Hit i: mask[i] and x0<=x<x0+w and y0<=y<y0+h, sums computed COORD_W+1 bits wide (no wrap; rectangles past edge are clipped). w=0 or h=0 never hits.
- Priority: lowest-index hitting sprite wins; no hit -> background.
- Blanked pixels output 0 on all colour channels.
- Reset: counters 0, mask 0, all sprite fields 0, background 24'h150088, oBLANK_n 0, oHS=oVS=~SYNC_POL, colour outputs 0, oFRAME 0. Reset mid-frame restarts at h=0,v=0 next cycle.

## Timing
- 3-stage pipeline: S0 counters, S1 hit compare (registered hit vector + coordinates), S2 priority mux + output register.
- Colour, oHS, oVS, oBLANK_n all delayed exactly 2 cycles from counter state; they stay mutually aligned.
- oFRAME asserted in the cycle S2 presents h=0, v=V_ACTIVE.
- Register write at cycle n visible to the compare stage from cycle n+1 (without frame latch).
- Write and frame boundary in same cycle: the write lands in the live set (latched variant: it is committed by that boundary).

## Configuration
- VGA_FRAME_LATCH_EN defined: writes go to shadow registers; all shadow values copied to live set in the cycle S0 reaches h=0, v=V_ACTIVE (start of vertical blank); no mid-frame tearing. Reset clears both sets identically.
- Undefined: no shadow set; writes act on live registers immediately (may change mid-line).

## Test plan
- Reset, default params, run 800*525 cycles -> exactly 525 HS pulses of 96 cycles, one VS of 2 lines, 640*480 cycles with oBLANK_n=1, all pixels 24'h150088, one oFRAME.
- Sprite0 x0=100,y0=50,w=20,h=10,colour 24'h0000FF, mask=1 -> r_data=FF exactly at x 100..119, y 50..59; x=120 and y=60 background.
- Sprites 0 and 1 overlapping, different colours -> overlap shows sprite 0; clear mask bit 0 -> overlap shows sprite 1.
- Sprite x0=630,w=50 -> pixels 630..639 coloured, no wrap onto x 0..39 of next line.
- Write colour mid-frame at v=200: with VGA_FRAME_LATCH_EN unchanged until next frame; without, changes from v=200 onward.
- Assert iRST for one cycle at v=300 -> outputs take reset values, next VS after exactly 490 lines.
